alu_flag_unit: RTL and testbench
================================

# alu_flag_unit

Execute-stage back end for the 64-bit ALU. Accepts one ALU result plus its negative/zero/overflow/carry_out flags per transaction, holds the architectural NZCV flag register, and resolves conditional-branch outcomes. It sits between the ALU and the branch/writeback logic. The result, the branch decision and the current flags are presented through a one-entry registered output with a valid/ready handshake.

## Interface
Parameters:
- WIDTH, 64, data width of the result path.

Ports:
- clk  input  1  the single clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-high.
- in_valid  input  1  upstream transaction present.
- in_ready  output  1  unit can accept this cycle.
- in_result  input  WIDTH  ALU result.
- in_negative, in_zero, in_overflow, in_carry_out  input  1 each  ALU flags for in_result.
- in_set_flags  input  1  transaction updates NZCV (ADDS/SUBS style).
- in_is_branch  input  1  transaction is a conditional branch.
- in_cbz  input  1  compare-and-branch on in_zero; used only with ALU_CBZ_EN.
- in_cond  input  4  condition code; for CBZ, bit 0 selects CBZ (0) or CBNZ (1).
- out_valid  output  1  output register holds a transaction.
- out_ready  input  1  downstream accepts.
- out_result  output  WIDTH  registered in_result.
- out_taken  output  1  registered branch decision.
- flags_nzcv  output  4  architectural flags {N,Z,C,V}, registered.

## Operation
- Accept = in_valid && in_ready. Output: in_ready = !reset && (!out_valid || out_ready).
- On accept:
  - out_result <= in_result.
  - out_valid <= 1.
  - out_taken <= in_is_branch && cond_true.
  - If in_set_flags, NZCV <= {in_negative, in_zero, in_carry_out, in_overflow}.
- cond_true is evaluated against the NZCV value held before this accept. A transaction with both in_set_flags and in_is_branch therefore branches on the old flags, then updates them.
- Condition codes:
  - 0 EQ Z; 1 NE !Z; 2 HS C; 3 LO !C.
  - 4 MI N; 5 PL !N; 6 VS V; 7 VC !V.
  - 8 HI C&!Z; 9 LS !(C&!Z).
  - 10 GE N==V; 11 LT N!=V.
  - 12 GT !Z&(N==V); 13 LE !(!Z&(N==V)).
  - 14 and 15 are always true.
- in_is_branch = 0 gives out_taken = 0 regardless of in_cond.
- When no accept occurs and out_ready = 1, out_valid <= 0. out_result and out_taken keep their last values.
- While out_valid = 1 and out_ready = 0, all out_* signals are held stable.
- NZCV changes only on an accept with in_set_flags = 1.

## Timing
- Reset values: out_valid 0, out_result 0, out_taken 0, flags_nzcv 4'b0000, in_ready 0 while reset is high.
- Latency: 1 cycle from accept to out_valid.
- flags_nzcv reflects the new flags the cycle after a flag-setting accept.
- Throughput: one transaction per cycle while out_ready = 1. Simultaneous drain and accept in the same cycle is required.
- Back-to-back dependency: a flag-setting transaction accepted in cycle t is visible to the branch condition of a transaction accepted in cycle t+1. No bubble.
- Reset asserted mid-operation discards any held transaction and clears NZCV immediately, without waiting for a clock edge.
- The first edge after reset deasserts may accept a transaction.

## Configuration
- ALU_CBZ_EN defined:
  - in_is_branch && in_cbz evaluates in_zero of the same transaction instead of NZCV.
  - CBZ is taken if in_zero = 1; CBNZ is taken if in_zero = 0.
  - NZCV is unaffected unless in_set_flags = 1.
- ALU_CBZ_EN undefined:
  - in_cbz is ignored (treated as 0).
  - Every branch uses the in_cond table.

## Structure
- The shared package alu_pkg holds:
  - The ALU cntrl constants (PASS_B 000, ADD 010, SUBTRACT 011, AND 100, OR 101, XOR 110).
  - The 4-bit cond_t enum (EQ…NV).
  - The NZCV index constants.
- One combinational sub-module, alu_cond_eval, holds the condition table and CBZ logic. It takes nzcv, in_cond, in_cbz, in_zero and returns cond_true.
- The top level holds the NZCV register and the output register/handshake.

## Test plan
- Reset with in_valid = 1 → in_ready = 0, out_valid = 0, flags_nzcv = 0000. After reset deasserts, the first edge accepts.
- SUBS of 1−1 (result 0, zero = 1, carry_out = 1) with set_flags, then branch cond = 0 (EQ) next cycle → out_taken = 1, flags_nzcv = 0110. Follow with cond = 1 (NE) → out_taken = 0.
- ADDS 0x3000…0 + 0x6000…0 (result 0x9000…0, N = 1, V = 1) → flags_nzcv = 1001. Branch GE → taken; LT → not taken.
- One transaction with both set_flags and is_branch EQ, prior Z = 0, in_zero = 1 → out_taken = 0. Then flags_nzcv.Z = 1.
- Hold out_ready = 0 for 3 cycles with in_valid = 1 → in_ready = 0, out_result stable, NZCV unchanged. Release → drain and accept in the same cycle.
- With ALU_CBZ_EN defined: in_cbz = 1, in_cond = 0, in_zero = 1 → taken; in_cond = 1 → not taken. Without ALU_CBZ_EN, the same stimulus follows EQ/NE on the stored NZCV.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: ALU control encodings, branch condition codes and
// the bit positions of the N/Z/C/V fields in the architectural flag register.
package alu_pkg;

  // ALU operation select (cntrl) encodings
  localparam logic [2:0] ALU_PASS_B   = 3'b000;
  localparam logic [2:0] ALU_ADD      = 3'b010;
  localparam logic [2:0] ALU_SUBTRACT = 3'b011;
  localparam logic [2:0] ALU_AND      = 3'b100;
  localparam logic [2:0] ALU_OR       = 3'b101;
  localparam logic [2:0] ALU_XOR      = 3'b110;

  // Flag register layout {N,Z,C,V}
  localparam int unsigned NZCV_W = 4;
  localparam int unsigned NZCV_N = 3;
  localparam int unsigned NZCV_Z = 2;
  localparam int unsigned NZCV_C = 1;
  localparam int unsigned NZCV_V = 0;

  localparam int unsigned COND_W = 4;

  typedef enum logic [COND_W-1:0] {
    COND_EQ = 4'd0,
    COND_NE = 4'd1,
    COND_HS = 4'd2,
    COND_LO = 4'd3,
    COND_MI = 4'd4,
    COND_PL = 4'd5,
    COND_VS = 4'd6,
    COND_VC = 4'd7,
    COND_HI = 4'd8,
    COND_LS = 4'd9,
    COND_GE = 4'd10,
    COND_LT = 4'd11,
    COND_GT = 4'd12,
    COND_LE = 4'd13,
    COND_AL = 4'd14,
    COND_NV = 4'd15
  } cond_t;

endpackage

// File: rtl/alu_cond_eval.sv
// Branch condition evaluator: resolves a condition code against the current
// NZCV flags. With ALU_CBZ_EN defined, a CBZ/CBNZ branch instead tests the
// zero flag of its own transaction (cond bit 0 picks CBNZ).
module alu_cond_eval
  import alu_pkg::*;
(
  input  logic [NZCV_W-1:0] nzcv_i,
  input  logic [COND_W-1:0] cond_i,
  input  logic              cbz_i,
  input  logic              zero_i,
  output logic              cond_true_o
);

  logic n_flag;
  logic z_flag;
  logic c_flag;
  logic v_flag;

  assign n_flag = nzcv_i[NZCV_N];
  assign z_flag = nzcv_i[NZCV_Z];
  assign c_flag = nzcv_i[NZCV_C];
  assign v_flag = nzcv_i[NZCV_V];

`ifndef ALU_CBZ_EN
  // Operand-zero and CBZ inputs only matter when compare-and-branch is built in
  logic unused_cbz_inputs;
  assign unused_cbz_inputs = cbz_i | zero_i;
`endif

  // Condition table lookup, overridden by compare-and-branch when enabled
  always_comb begin
    cond_true_o = 1'b1;
    case (cond_t'(cond_i))
      COND_EQ: cond_true_o = z_flag;
      COND_NE: cond_true_o = !z_flag;
      COND_HS: cond_true_o = c_flag;
      COND_LO: cond_true_o = !c_flag;
      COND_MI: cond_true_o = n_flag;
      COND_PL: cond_true_o = !n_flag;
      COND_VS: cond_true_o = v_flag;
      COND_VC: cond_true_o = !v_flag;
      COND_HI: cond_true_o = c_flag && !z_flag;
      COND_LS: cond_true_o = !(c_flag && !z_flag);
      COND_GE: cond_true_o = (n_flag == v_flag);
      COND_LT: cond_true_o = (n_flag != v_flag);
      COND_GT: cond_true_o = !z_flag && (n_flag == v_flag);
      COND_LE: cond_true_o = !(!z_flag && (n_flag == v_flag));
      default: cond_true_o = 1'b1;
    endcase
`ifdef ALU_CBZ_EN
    if (cbz_i) begin
      cond_true_o = cond_i[0] ? !zero_i : zero_i;
    end
`endif
  end

endmodule

// File: rtl/alu_flag_unit.sv
// Execute-stage back end: holds the architectural NZCV flags, resolves
// conditional branches against the flags held before each accept, and
// presents result/taken/flags through a one-entry registered output stage.
// Optional feature macro: ALU_CBZ_EN (compare-and-branch on operand zero).
module alu_flag_unit
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_result,
  input  logic              in_negative,
  input  logic              in_zero,
  input  logic              in_overflow,
  input  logic              in_carry_out,
  input  logic              in_set_flags,
  input  logic              in_is_branch,
  input  logic              in_cbz,
  input  logic [COND_W-1:0] in_cond,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_result,
  output logic              out_taken,
  output logic [NZCV_W-1:0] flags_nzcv
);

  logic              out_valid_q;
  logic [WIDTH-1:0]  out_result_q;
  logic              out_taken_q;
  logic [NZCV_W-1:0] nzcv_q;
  logic [NZCV_W-1:0] nzcv_d;
  logic              cond_true;
  logic              taken_d;
  logic              accept;

  // Branch condition sees the flags as they stood before this accept
  alu_cond_eval u_cond_eval (
    .nzcv_i      (nzcv_q),
    .cond_i      (in_cond),
    .cbz_i       (in_cbz),
    .zero_i      (in_zero),
    .cond_true_o (cond_true)
  );

  // Output slot is free when empty or draining this cycle
  assign in_ready = !reset && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;
  assign taken_d  = in_is_branch && cond_true;
  assign nzcv_d   = {in_negative, in_zero, in_carry_out, in_overflow};

  // Output register, handshake state and architectural flags
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_taken_q  <= 1'b0;
      nzcv_q       <= '0;
    end else if (accept) begin
      out_valid_q  <= 1'b1;
      out_result_q <= in_result;
      out_taken_q  <= taken_d;
      if (in_set_flags) begin
        nzcv_q <= nzcv_d;
      end
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_result = out_result_q;
  assign out_taken  = out_taken_q;
  assign flags_nzcv = nzcv_q;

endmodule

// File: tb/tb_alu_flag_unit.sv
// Self-checking bench for alu_flag_unit: directed scenarios with literal
// expectations followed by randomized traffic against a behavioural model.
// Honours ALU_CBZ_EN the same way the design does.
module tb_alu_flag_unit;

  localparam int unsigned W = 64;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_result = '0;
  logic         in_negative = 1'b0;
  logic         in_zero = 1'b0;
  logic         in_overflow = 1'b0;
  logic         in_carry_out = 1'b0;
  logic         in_set_flags = 1'b0;
  logic         in_is_branch = 1'b0;
  logic         in_cbz = 1'b0;
  logic [3:0]   in_cond = 4'd0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] out_result;
  logic         out_taken;
  logic [3:0]   flags_nzcv;

  alu_flag_unit #(.WIDTH(W)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_result    (in_result),
    .in_negative  (in_negative),
    .in_zero      (in_zero),
    .in_overflow  (in_overflow),
    .in_carry_out (in_carry_out),
    .in_set_flags (in_set_flags),
    .in_is_branch (in_is_branch),
    .in_cbz       (in_cbz),
    .in_cond      (in_cond),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_result   (out_result),
    .out_taken    (out_taken),
    .flags_nzcv   (flags_nzcv)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  bit check_en = 1'b0;

  // Behavioural model state
  bit         m_valid;
  bit [W-1:0] m_result;
  bit         m_taken;
  bit [3:0]   m_nzcv;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Condition as a base predicate on the even code, inverted by bit 0
  function automatic bit cond_holds(input bit [3:0] f, input bit [3:0] c);
    bit n, z, cy, v, base;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    if (c >= 4'd14) return 1'b1;
    case (c >> 1)
      3'd0: base = z;
      3'd1: base = cy;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cy & ~z;
      3'd5: base = (n == v);
      default: base = ~z & (n == v);
    endcase
    return c[0] ? ~base : base;
  endfunction

  function automatic bit branch_taken(input bit [3:0] f);
`ifdef ALU_CBZ_EN
    if (in_cbz) return in_cond[0] ^ in_zero;
`endif
    return cond_holds(f, in_cond);
  endfunction

  function automatic bit m_ready();
    return !reset && (!m_valid || out_ready);
  endfunction

  task automatic model_clear();
    m_valid = 0; m_result = '0; m_taken = 0; m_nzcv = '0;
  endtask

  // Advance the model by one rising edge using the inputs the DUT saw
  task automatic model_edge();
    if (reset) begin
      model_clear();
    end else if (in_valid && m_ready()) begin
      m_taken  = in_is_branch && branch_taken(m_nzcv);
      m_result = in_result;
      m_valid  = 1;
      if (in_set_flags) m_nzcv = {in_negative, in_zero, in_carry_out, in_overflow};
    end else if (out_ready) begin
      m_valid = 0;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  // Compare process: every falling edge, all outputs against the model
  always @(negedge clk) begin
    if (check_en) begin
      chk("in_ready", W'(in_ready), W'(m_ready()));
      chk("out_valid", W'(out_valid), W'(m_valid));
      chk("out_result", out_result, m_result);
      chk("out_taken", W'(out_taken), W'(m_taken));
      chk("flags_nzcv", W'(flags_nzcv), W'(m_nzcv));
    end
  end

  task automatic drive(input bit v, input logic [W-1:0] r, input bit n, input bit z,
                       input bit c, input bit ov, input bit sf, input bit br,
                       input bit cbz, input bit [3:0] cond);
    in_valid = v; in_result = r; in_negative = n; in_zero = z; in_carry_out = c;
    in_overflow = ov; in_set_flags = sf; in_is_branch = br; in_cbz = cbz; in_cond = cond;
  endtask

  logic [W-1:0] held;
  logic [3:0]   held_f;

  initial begin
    model_clear();
    #1 reset = 1'b1;
    drive(1, 64'h55, 0, 0, 0, 0, 1, 0, 0, 0);
    #1;
    chk("rst_in_ready", W'(in_ready), W'(0));
    chk("rst_out_valid", W'(out_valid), W'(0));
    chk("rst_flags", W'(flags_nzcv), W'(0));
    check_en = 1'b1;
    cycle();
    cycle();
    reset = 1'b0;
    drive(1, 64'h5, 0, 0, 0, 0, 0, 0, 0, 0);
    cycle();
    chk("first_accept_valid", W'(out_valid), W'(1));
    chk("first_accept_result", out_result, 64'h5);

    // SUBS 1-1 then EQ, then NE
    drive(1, 64'h0, 0, 1, 1, 0, 1, 0, 0, 0);
    cycle();
    drive(1, 64'h10, 0, 0, 0, 0, 0, 1, 0, 4'd0);
    cycle();
    chk("eq_taken", W'(out_taken), W'(1));
    chk("subs_flags", W'(flags_nzcv), W'(4'b0110));
    drive(1, 64'h11, 0, 0, 0, 0, 0, 1, 0, 4'd1);
    cycle();
    chk("ne_taken", W'(out_taken), W'(0));

    // ADDS with signed overflow, then GE and LT
    drive(1, 64'h9000_0000_0000_0000, 1, 0, 0, 1, 1, 0, 0, 0);
    cycle();
    chk("adds_flags", W'(flags_nzcv), W'(4'b1001));
    drive(1, 64'h12, 0, 0, 0, 0, 0, 1, 0, 4'd10);
    cycle();
    chk("ge_taken", W'(out_taken), W'(1));
    drive(1, 64'h13, 0, 0, 0, 0, 0, 1, 0, 4'd11);
    cycle();
    chk("lt_taken", W'(out_taken), W'(0));

    // Set-flags branch resolves on old Z=0, then Z becomes 1
    drive(1, 64'h14, 0, 1, 0, 0, 1, 1, 0, 4'd0);
    cycle();
    chk("sf_branch_taken", W'(out_taken), W'(0));
    chk("sf_branch_flags", W'(flags_nzcv), W'(4'b0100));

    // Backpressure: three stalled cycles, then drain and accept together
    out_ready = 1'b0;
    held = out_result;
    held_f = flags_nzcv;
    drive(1, 64'hABCD, 0, 0, 0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("stall_in_ready", W'(in_ready), W'(0));
      chk("stall_result", out_result, held);
      chk("stall_flags", W'(flags_nzcv), W'(held_f));
    end
    out_ready = 1'b1;
    #1;
    chk("release_in_ready", W'(in_ready), W'(1));
    cycle();
    chk("release_result", out_result, 64'hABCD);
    chk("release_flags", W'(flags_nzcv), W'(4'b0000));

    // CBZ stimulus with stored Z=0 and operand zero=1
    drive(1, 64'h20, 0, 1, 0, 0, 0, 1, 1, 4'd0);
    cycle();
`ifdef ALU_CBZ_EN
    chk("cbz_taken", W'(out_taken), W'(1));
`else
    chk("cbz_taken", W'(out_taken), W'(0));
`endif
    drive(1, 64'h21, 0, 1, 0, 0, 0, 1, 1, 4'd1);
    cycle();
`ifdef ALU_CBZ_EN
    chk("cbnz_taken", W'(out_taken), W'(0));
`else
    chk("cbnz_taken", W'(out_taken), W'(1));
`endif

    // Asynchronous reset with a transaction held
    drive(1, 64'h77, 1, 1, 1, 1, 1, 0, 0, 0);
    cycle();
    reset = 1'b1;
    model_clear();
    #1;
    chk("async_rst_valid", W'(out_valid), W'(0));
    chk("async_rst_flags", W'(flags_nzcv), W'(0));
    cycle();
    reset = 1'b0;

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      drive(($urandom_range(3) != 0), {$urandom(), $urandom()}, 1'($urandom()),
            1'($urandom()), 1'($urandom()), 1'($urandom()), 1'($urandom()),
            1'($urandom()), 1'($urandom()), 4'($urandom()));
      out_ready = ($urandom_range(3) != 0);
      if ($urandom_range(299) == 0) begin
        reset = 1'b1;
        model_clear();
      end else begin
        reset = 1'b0;
      end
      cycle();
    end
    reset = 1'b0;
    cycle();
    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
